prefetch_fetch_unit: RTL

Parametrised instruction fetch unit that sits between the imem port and decode, replacing the single-word pass-through fetch stage. It issues pipelined sequential requests, tolerates multiple outstanding requests, and buffers returned words with their PCs in a small FIFO. On a branch or jump redirect it flushes the buffer and discards in-flight responses. It also suppresses requests while the shared memory path is busy with a load.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/prefetch_fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the prefetching instruction fetch unit.
package fetch_pkg;

    // Byte distance between consecutive instruction words
    localparam int FetchStep = 4;

    // Instruction fetches always read a full word
    localparam logic [3:0] Imask = 4'b1111;

    // Default geometry of the fetch unit
    localparam int DefDataWidth = 32;
    localparam int DefDepth     = 4;

    // Width of a counter that must represent 0..depth inclusive
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CntW = cntWidth(DefDepth);

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [DefDataWidth-1:0] pc;
        logic [DefDataWidth-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a single-cycle flush.
module sync_fifo #(
    parameter int Width = 64,
    parameter int Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rdPtr_q;
    logic [PtrW-1:0]  wrPtr_q;
    logic [CntW-1:0]  count_q;

    // Storage needs no reset; only entries between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because depth is a power of two; flush behaves like reset
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + PtrW'(1);
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Prefetching fetch stage: pipelined sequential imem requests, in-order
// response buffering with PCs, and redirect flushing of stale responses.
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   DataWidth      = DefDataWidth,
    parameter int                   Depth          = DefDepth,
    parameter int                   MaxOutstanding = 2,
    parameter logic [DataWidth-1:0] ResetPc        = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_stall,
    input  logic                 redirect,
    input  logic [DataWidth-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [DataWidth-1:0] imem_addr,
    output logic [3:0]           imem_mask,
    output logic                 imem_we_re,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [DataWidth-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [DataWidth-1:0] instr,
    output logic [DataWidth-1:0] instr_pc,
    input  logic                 instr_ready
);

    localparam int CntBits = cntWidth(Depth);
    localparam int SumBits = CntBits + 1;

    logic [DataWidth-1:0] fetchPc_q, fetchPc_d;
    logic [DataWidth-1:0] respPc_q, respPc_d;
    logic [CntBits-1:0]   outstanding_q, outstanding_d;
    logic [CntBits-1:0]   drop_q, drop_d;

    logic [CntBits-1:0]     fifoCount;
    logic                   fifoEmpty;
    logic [2*DataWidth-1:0] fifoHead;
    logic [SumBits-1:0]     slotsClaimed;
    logic                   issueOk;
    logic                   accept;
    logic                   rspValid;
    logic                   pushEn;
    logic                   popEn;
    logic [DataWidth-1:0]   redirectAligned;
    logic                   unusedPcBits;

    assign redirectAligned = {redirect_pc[DataWidth-1:2], 2'b00};
    assign unusedPcBits    = ^redirect_pc[1:0];

    // Every accepted request already owns a FIFO slot, so responses never need back-pressure
    assign slotsClaimed = SumBits'(fifoCount) + SumBits'(outstanding_q) - SumBits'(drop_q);
    assign issueOk      = !mem_stall && !redirect
                          && (outstanding_q < CntBits'(MaxOutstanding))
                          && (slotsClaimed < SumBits'(Depth));

    assign imem_req   = issueOk && !rst;
    assign imem_addr  = fetchPc_q;
    assign imem_mask  = Imask;
    assign imem_we_re = 1'b0;

    // A response with nothing outstanding is ignored rather than corrupting the counters
    assign accept   = imem_req && imem_ready;
    assign rspValid = imem_rvalid && (outstanding_q != '0);
    assign pushEn   = rspValid && (drop_q == '0) && !redirect;
    assign popEn    = !fifoEmpty && instr_ready && !redirect;

    // Next-state for PCs and counters; a redirect overrides everything else
    always_comb begin
        fetchPc_d     = fetchPc_q;
        respPc_d      = respPc_q;
        outstanding_d = outstanding_q + CntBits'(accept) - CntBits'(rspValid);
        drop_d        = drop_q;
        if (accept) begin
            fetchPc_d = fetchPc_q + DataWidth'(FetchStep);
        end
        if (pushEn) begin
            respPc_d = respPc_q + DataWidth'(FetchStep);
        end
        if (rspValid && (drop_q != '0)) begin
            drop_d = drop_q - CntBits'(1);
        end
        if (redirect) begin
            fetchPc_d = redirectAligned;
            respPc_d  = redirectAligned;
            drop_d    = outstanding_d;
        end
    end

    // State registers for the fetch and response PCs and the in-flight bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q     <= ResetPc;
            respPc_q      <= ResetPc;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            respPc_q      <= respPc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    sync_fifo #(
        .Width (2 * DataWidth),
        .Depth (Depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (pushEn),
        .data_i  ({respPc_q, imem_rdata}),
        .pop_i   (popEn),
        .data_o  (fifoHead),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign instr_valid = !fifoEmpty && !rst;
    assign instr_pc    = instr_valid ? fifoHead[2*DataWidth-1:DataWidth] : '0;
    assign instr       = instr_valid ? fifoHead[DataWidth-1:0] : '0;

    rvalidWithoutRequest: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (outstanding_q != '0));

endmodule
